// File: rtl/enc_pkg.sv
// Shared definitions for the streaming 8-to-3 priority encoder:
// FSM state encoding, widths and a small bit-count helper.
package enc_pkg;

  localparam int N  = 8;
  localparam int AW = 3;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t EMIT = 1'b1;

  localparam logic [N-1:0] LSB_ONE = {{(N-1){1'b0}}, 1'b1};

  // True when v has zero or one bit set (clearing the lowest set bit leaves nothing).
  function automatic logic at_most_one(input logic [N-1:0] v);
    return (v & (v - LSB_ONE)) == '0;
  endfunction

endpackage

// File: rtl/pe8to3.sv
// Combinational priority encoder: picks the highest (msb_first=1) or lowest
// set bit of vec and returns its index, an any-set flag and a one-hot mask.
module pe8to3
  import enc_pkg::*;
(
  input  logic [N-1:0]  vec,
  input  logic          msb_first,
  output logic [AW-1:0] idx,
  output logic          any,
  output logic [N-1:0]  mask
);

  // Later loop iterations override earlier ones, so scan order sets priority.
  always_comb begin
    idx = '0;
    if (msb_first) begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = AW'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = AW'(i);
      end
    end
  end

  assign any  = |vec;
  assign mask = any ? (LSB_ONE << idx) : '0;

endmodule

// File: rtl/encoder8to3_stream.sv
// Streaming priority encoder: latches one request vector, then emits the index
// of every set bit as a separate beat (or one V=0 beat for an empty vector).
module encoder8to3_stream
  import enc_pkg::state_t, enc_pkg::IDLE, enc_pkg::EMIT, enc_pkg::at_most_one;
#(
  parameter int N         = 8,
  parameter int AW        = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  D,
  input  logic          E,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] A,
  output logic          V,
  output logic          last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is high only in IDLE and out_valid only in EMIT, so the
  // two sides never transfer in the same cycle; while out_ready is low the beat
  // (A/V/last) and the pending register hold.

  state_t          state;
  logic [N-1:0]    pending;
  logic [AW-1:0]   pe_idx;
  logic            pe_any;
  logic [N-1:0]    pe_mask;
  logic            emit;
  logic            single;

  pe8to3 u_pe (
    .vec       (pending),
    .msb_first (MSB_FIRST),
    .idx       (pe_idx),
    .any       (pe_any),
    .mask      (pe_mask)
  );

  assign emit   = (state == EMIT);
  assign single = at_most_one(pending);

  assign in_ready  = (state == IDLE);
  assign out_valid = emit;
  assign A         = emit ? pe_idx : '0;
  assign V         = emit & pe_any;
  assign last      = emit & single;
  assign dbg_state = state[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pending <= E ? D : '0;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            pending <= pending & ~pe_mask;
            if (single) state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
        end
      endcase
    end
  end

endmodule
